// File: rtl/vga_pkg.sv
// Purpose: shared 640x480@60 timing defaults, bus widths and the raster flag bundle.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents: default porch/sync/visible constants, derived totals, coordinate and
// colour widths, and rasterFlags_t (visible + active-high raw syncs).
package vga_pkg;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    localparam int COORD_W = 10;
    localparam int COLOR_W = 8;

    // Syncs are carried active-high internally; pin polarity is applied only
    // at the output register.
    typedef struct packed {
        logic visible;
        logic hsync;
        logic vsync;
    } rasterFlags_t;

endpackage

// File: rtl/vga_delay_line.sv
// Purpose: fixed-depth shift register used to align raster flags with the render pipeline.
// Latency: DEPTH clocks (DEPTH=0 is a straight wire).
// Backpressure: none; shifts on every clock.
//
// Ports: clock, reset (async, active-high, loads RESET_VALUE into every stage),
//        dataIn [WIDTH], dataOut [WIDTH].
module vga_delay_line #(
    parameter int               WIDTH       = 1,
    parameter int               DEPTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] dataIn,
    output logic [WIDTH-1:0] dataOut
);

    generate
        if (DEPTH == 0) begin : gBypass
            assign dataOut = dataIn;
        end else begin : gShift
            logic [WIDTH-1:0] stages [DEPTH];

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stages[i] <= RESET_VALUE;
                    end
                end else begin
                    stages[0] <= dataIn;
                    for (int i = 1; i < DEPTH; i++) begin
                        stages[i] <= stages[i-1];
                    end
                end
            end

            assign dataOut = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose: 640x480@60 raster counters, coordinate/strobe decodes, and registered VGA pins.
// Latency: coordinates immediate; pins lag coordinates by PIXEL_LATENCY+1 clocks.
// Backpressure: enable=0 freezes the raster; the pin pipeline keeps shifting.
//
// Ports: clock25MHz, reset (async, active-high), enable; xOrd/yOrd/visible/lineStart/
//        frameStart to renderers; pixR/G/B from compositor; vgaR/G/B/vgaHsync/vgaVsync pins;
//        frameCount (real counter only when VGA_FRAME_COUNT_EN is defined, else 0).
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE       = H_VISIBLE_DEF,
    parameter int H_FRONT         = H_FRONT_DEF,
    parameter int H_SYNC          = H_SYNC_DEF,
    parameter int H_BACK          = H_BACK_DEF,
    parameter int V_VISIBLE       = V_VISIBLE_DEF,
    parameter int V_FRONT         = V_FRONT_DEF,
    parameter int V_SYNC          = V_SYNC_DEF,
    parameter int V_BACK          = V_BACK_DEF,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int PIXEL_LATENCY   = 1
) (
    input  logic               clock25MHz,
    input  logic               reset,
    input  logic               enable,
    output logic [COORD_W-1:0] xOrd,
    output logic [COORD_W-1:0] yOrd,
    output logic               visible,
    output logic               lineStart,
    output logic               frameStart,
    input  logic [COLOR_W-1:0] pixR,
    input  logic [COLOR_W-1:0] pixG,
    input  logic [COLOR_W-1:0] pixB,
    output logic [COLOR_W-1:0] vgaR,
    output logic [COLOR_W-1:0] vgaG,
    output logic [COLOR_W-1:0] vgaB,
    output logic               vgaHsync,
    output logic               vgaVsync,
    output logic [15:0]        frameCount
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_VISIBLE);
    localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_VISIBLE);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_VISIBLE + H_FRONT);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_VISIBLE + V_FRONT);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);

    // Pin level when a sync is not pulsing.
    localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

    logic [COORD_W-1:0] hCount;
    logic [COORD_W-1:0] vCount;
    logic               hWrap;
    rasterFlags_t       rawFlags;
    rasterFlags_t       delayedFlags;

    assign hWrap = (hCount == H_LAST);

    // Reset parks the counters on the last clock of the frame so the first
    // enabled edge lands exactly on (0,0) with frameStart.
    always_ff @(posedge clock25MHz or posedge reset) begin
        if (reset) begin
            hCount <= H_LAST;
            vCount <= V_LAST;
        end else if (enable) begin
            if (hWrap) begin
                hCount <= '0;
                vCount <= (vCount == V_LAST) ? '0 : vCount + 1'b1;
            end else begin
                hCount <= hCount + 1'b1;
            end
        end
    end

    assign xOrd       = hCount;
    assign yOrd       = vCount;
    assign lineStart  = (hCount == '0);
    assign frameStart = (hCount == '0) && (vCount == '0);
    assign visible    = rawFlags.visible;

    always_comb begin
        rawFlags         = '0;
        rawFlags.visible = (hCount < H_VIS) && (vCount < V_VIS);
        rawFlags.hsync   = (hCount >= HS_START) && (hCount < HS_END);
        rawFlags.vsync   = (vCount >= VS_START) && (vCount < VS_END);
    end

    vga_delay_line #(
        .WIDTH       ($bits(rasterFlags_t)),
        .DEPTH       (PIXEL_LATENCY),
        .RESET_VALUE ('0)
    ) uFlagDelay (
        .clock   (clock25MHz),
        .reset   (reset),
        .dataIn  (rawFlags),
        .dataOut (delayedFlags)
    );

    // Pin register: RGB is forced black outside the visible area, and the
    // XOR with SYNC_IDLE inverts the active-high syncs for active-low pins.
    always_ff @(posedge clock25MHz or posedge reset) begin
        if (reset) begin
            vgaR     <= '0;
            vgaG     <= '0;
            vgaB     <= '0;
            vgaHsync <= SYNC_IDLE;
            vgaVsync <= SYNC_IDLE;
        end else begin
            vgaR     <= delayedFlags.visible ? pixR : '0;
            vgaG     <= delayedFlags.visible ? pixG : '0;
            vgaB     <= delayedFlags.visible ? pixB : '0;
            vgaHsync <= delayedFlags.hsync ^ SYNC_IDLE;
            vgaVsync <= delayedFlags.vsync ^ SYNC_IDLE;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic        frameWrap;
    logic [15:0] frameCountQ;

    // Counts the edges that move the raster onto (0,0), i.e. frames started.
    assign frameWrap = hWrap && (vCount == V_LAST);

    always_ff @(posedge clock25MHz or posedge reset) begin
        if (reset) begin
            frameCountQ <= '0;
        end else if (enable && frameWrap) begin
            frameCountQ <= frameCountQ + 16'd1;
        end
    end

    assign frameCount = frameCountQ;
`else
    assign frameCount = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

`ifdef VGA_FRAME_COUNT_EN
    localparam int FC_EN = 1;
`else
    localparam int FC_EN = 0;
`endif

    logic clk = 1'b0;
    always #20 clk = ~clk;

    // Full-size instance (A) and a shrunken raster (S) for frame-level behaviour.
    logic       rstA, enA, visA, lsA, fsA, hsA, vsA;
    logic [9:0] xA, yA;
    logic [7:0] pixRA, pixGA, pixBA, vgaRA, vgaGA, vgaBA;
    logic [15:0] fcA;
    logic       rstS, enS, visS, lsS, fsS, hsS, vsS;
    logic [9:0] xS, yS;
    logic [7:0] pixRS, pixGS, pixBS, vgaRS, vgaGS, vgaBS;
    logic [15:0] fcS;

    vga_timing_gen dutA (
        .clock25MHz(clk), .reset(rstA), .enable(enA),
        .xOrd(xA), .yOrd(yA), .visible(visA), .lineStart(lsA), .frameStart(fsA),
        .pixR(pixRA), .pixG(pixGA), .pixB(pixBA),
        .vgaR(vgaRA), .vgaG(vgaGA), .vgaB(vgaBA),
        .vgaHsync(hsA), .vgaVsync(vsA), .frameCount(fcA)
    );

    // 24 clocks/line (hsync x=18..21), 10 lines/frame (vsync y=7..8), 240 clocks/frame.
    vga_timing_gen #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .SYNC_ACTIVE_LOW(1), .PIXEL_LATENCY(1)
    ) dutS (
        .clock25MHz(clk), .reset(rstS), .enable(enS),
        .xOrd(xS), .yOrd(yS), .visible(visS), .lineStart(lsS), .frameStart(fsS),
        .pixR(pixRS), .pixG(pixGS), .pixB(pixBS),
        .vgaR(vgaRS), .vgaG(vgaGS), .vgaB(vgaBS),
        .vgaHsync(hsS), .vgaVsync(vsS), .frameCount(fcS)
    );

    localparam int SX = 0, SY = 1, SVIS = 2, SLS = 3, SFS = 4, SR = 5, SG = 6, SB = 7,
                   SHS = 8, SVS = 9, SFC = 10, SMALL = 16;

    typedef struct {
        int at;
        int sig;
        int exp;
    } exp_t;

    exp_t sbQ[$];
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int baseA = -1;
    int baseS = -1;
    int winAB = 0, winAH = 0, winSV = 0, winSB = 0, winSF = 0, winSL = 0;
    logic [9:0] lastX = '0;
    logic [9:0] lastY = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int sig);
        case (sig)
            SX:          return 32'(xA);
            SY:          return 32'(yA);
            SVIS:        return 32'(visA);
            SLS:         return 32'(lsA);
            SFS:         return 32'(fsA);
            SR:          return 32'(vgaRA);
            SG:          return 32'(vgaGA);
            SB:          return 32'(vgaBA);
            SHS:         return 32'(hsA);
            SVS:         return 32'(vsA);
            SFC:         return 32'(fcA);
            SMALL + SX:  return 32'(xS);
            SMALL + SY:  return 32'(yS);
            SMALL + SVIS: return 32'(visS);
            SMALL + SLS: return 32'(lsS);
            SMALL + SFS: return 32'(fsS);
            SMALL + SR:  return 32'(vgaRS);
            SMALL + SG:  return 32'(vgaGS);
            SMALL + SB:  return 32'(vgaBS);
            SMALL + SHS: return 32'(hsS);
            SMALL + SVS: return 32'(vsS);
            SMALL + SFC: return 32'(fcS);
            default:     return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic string sigName(input int sig);
        string names[11] = '{"xOrd", "yOrd", "visible", "lineStart", "frameStart",
                             "vgaR", "vgaG", "vgaB", "vgaHsync", "vgaVsync", "frameCount"};
        return {(sig >= SMALL) ? "S." : "A.", names[sig % SMALL]};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic expectAt(input int at, input int sig, input int v);
        exp_t e;
        e.at  = at;
        e.sig = sig;
        e.exp = v;
        sbQ.push_back(e);
    endtask

    // Advance to posedge #1 of absolute cycle t.
    task automatic waitCyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Fake renderer with one clock of latency: pixel for the coordinate of
    // the previous cycle, R=x, G=y, B=constant FF.
    initial begin
        pixRA = '0; pixGA = '0; pixBA = 8'hFF;
        pixRS = 8'hFF; pixGS = 8'hFF; pixBS = 8'hFF;
        forever begin
            @(negedge clk);
            pixRA = lastX[7:0];
            pixGA = lastY[7:0];
            lastX = xA;
            lastY = yA;
        end
    end

    // Monitor: compare every expectation due this cycle, plus window counters.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = sbQ.size() - 1; i >= 0; i--) begin
                if (sbQ[i].at == cyc) begin
                    check($sformatf("%s@%0d", sigName(sbQ[i].sig), sbQ[i].at),
                          actual(sbQ[i].sig), 32'(sbQ[i].exp));
                    sbQ.delete(i);
                end else if (sbQ[i].at < cyc) begin
                    check($sformatf("late_%s", sigName(sbQ[i].sig)), 32'(cyc), 32'(sbQ[i].at));
                    sbQ.delete(i);
                end
            end
            if (baseA >= 0 && cyc - baseA >= 800 && cyc - baseA < 1600) begin
                if (vgaBA == 8'hFF) winAB++;
                if (!hsA) winAH++;
            end
            if (baseS >= 0 && cyc - baseS >= 240 && cyc - baseS < 480) begin
                if (!vsS) winSV++;
                if (vgaBS == 8'hFF) winSB++;
                if (fsS) winSF++;
                if (lsS) winSL++;
            end
        end
    end

    task automatic runA();
        int b;
        rstA = 1'b1;
        enA  = 1'b1;
        waitCyc(3);
        expectAt(cyc, SX, 799);  expectAt(cyc, SY, 524);  expectAt(cyc, SVIS, 0);
        expectAt(cyc, SLS, 0);   expectAt(cyc, SFS, 0);   expectAt(cyc, SB, 0);
        expectAt(cyc, SHS, 1);   expectAt(cyc, SVS, 1);   expectAt(cyc, SFC, 0);
        waitCyc(4);
        rstA  = 1'b0;
        b     = cyc + 1;
        baseA = b;
        expectAt(b + 0, SX, 0);     expectAt(b + 0, SY, 0);    expectAt(b + 0, SVIS, 1);
        expectAt(b + 0, SLS, 1);    expectAt(b + 0, SFS, 1);   expectAt(b + 0, SHS, 1);
        expectAt(b + 0, SFC, FC_EN);
        expectAt(b + 1, SLS, 0);    expectAt(b + 1, SFS, 0);   expectAt(b + 1, SB, 0);
        expectAt(b + 2, SB, 255);   expectAt(b + 2, SR, 0);
        expectAt(b + 5, SR, 3);     expectAt(b + 5, SG, 0);
        expectAt(b + 639, SVIS, 1); expectAt(b + 640, SVIS, 0); expectAt(b + 640, SX, 640);
        expectAt(b + 641, SR, 127); expectAt(b + 641, SB, 255);
        expectAt(b + 642, SR, 0);   expectAt(b + 642, SB, 0);
        expectAt(b + 656, SX, 656); expectAt(b + 656, SHS, 1); expectAt(b + 657, SHS, 1);
        expectAt(b + 658, SHS, 0);  expectAt(b + 753, SHS, 0); expectAt(b + 754, SHS, 1);
        expectAt(b + 799, SX, 799); expectAt(b + 799, SY, 0);
        expectAt(b + 800, SX, 0);   expectAt(b + 800, SY, 1);  expectAt(b + 800, SLS, 1);
        expectAt(b + 800, SFS, 0);  expectAt(b + 800, SVS, 1);
        expectAt(b + 4101, SR, 99); expectAt(b + 4102, SR, 100);
        expectAt(b + 4105, SX, 100); expectAt(b + 4105, SY, 5); expectAt(b + 4110, SX, 100);
        expectAt(b + 4111, SX, 101); expectAt(b + 4111, SY, 5);
        expectAt(b + 4112, SR, 100); expectAt(b + 4112, SG, 5);
        expectAt(b + 4113, SR, 101); expectAt(b + 4114, SR, 102);
        waitCyc(b + 4100);
        enA = 1'b0;
        waitCyc(b + 4110);
        enA = 1'b1;
        waitCyc(b + 4120);
    endtask

    task automatic runS();
        int b;
        int b2;
        rstS = 1'b1;
        enS  = 1'b1;
        waitCyc(6);
        expectAt(cyc, SMALL + SX, 23); expectAt(cyc, SMALL + SY, 9);
        expectAt(cyc, SMALL + SHS, 1); expectAt(cyc, SMALL + SVS, 1);
        expectAt(cyc, SMALL + SB, 0);  expectAt(cyc, SMALL + SFC, 0);
        waitCyc(7);
        rstS  = 1'b0;
        b     = cyc + 1;
        baseS = b;
        expectAt(b + 0, SMALL + SX, 0);    expectAt(b + 0, SMALL + SY, 0);
        expectAt(b + 0, SMALL + SFS, 1);   expectAt(b + 0, SMALL + SLS, 1);
        expectAt(b + 0, SMALL + SFC, FC_EN);
        expectAt(b + 1, SMALL + SB, 0);    expectAt(b + 2, SMALL + SB, 255);
        expectAt(b + 23, SMALL + SX, 23);  expectAt(b + 23, SMALL + SY, 0);
        expectAt(b + 24, SMALL + SX, 0);   expectAt(b + 24, SMALL + SY, 1);
        expectAt(b + 24, SMALL + SLS, 1);  expectAt(b + 24, SMALL + SFS, 0);
        expectAt(b + 169, SMALL + SVS, 1); expectAt(b + 170, SMALL + SVS, 0);
        expectAt(b + 217, SMALL + SVS, 0); expectAt(b + 218, SMALL + SVS, 1);
        expectAt(b + 239, SMALL + SX, 23); expectAt(b + 239, SMALL + SY, 9);
        expectAt(b + 239, SMALL + SFS, 0); expectAt(b + 239, SMALL + SFC, FC_EN);
        expectAt(b + 240, SMALL + SFS, 1); expectAt(b + 240, SMALL + SFC, 2 * FC_EN);
        expectAt(b + 480, SMALL + SFC, 3 * FC_EN);
        // Reset mid-frame at (10,3) of the third frame; takes effect before the next edge.
        waitCyc(b + 562);
        rstS = 1'b1;
        expectAt(cyc, SMALL + SX, 23);  expectAt(cyc, SMALL + SY, 9);
        expectAt(cyc, SMALL + SVIS, 0); expectAt(cyc, SMALL + SFS, 0);
        expectAt(cyc, SMALL + SHS, 1);  expectAt(cyc, SMALL + SVS, 1);
        expectAt(cyc, SMALL + SB, 0);   expectAt(cyc, SMALL + SFC, 0);
        waitCyc(cyc + 3);
        rstS = 1'b0;
        b2   = cyc + 1;
        expectAt(b2 + 0, SMALL + SX, 0);    expectAt(b2 + 0, SMALL + SY, 0);
        expectAt(b2 + 0, SMALL + SFS, 1);   expectAt(b2 + 0, SMALL + SFC, FC_EN);
        expectAt(b2 + 1, SMALL + SB, 0);    expectAt(b2 + 2, SMALL + SB, 255);
        expectAt(b2 + 240, SMALL + SFS, 1); expectAt(b2 + 240, SMALL + SFC, 2 * FC_EN);
        waitCyc(b2 + 245);
    endtask

    initial begin
        rstA = 1'b1; enA = 1'b1;
        rstS = 1'b1; enS = 1'b1;
        fork
            runA();
            runS();
        join
        @(negedge clk);
        check("A.line1_rgb_on_clocks", 32'(winAB), 32'd640);
        check("A.line1_hsync_low_clocks", 32'(winAH), 32'd96);
        check("S.frame_vsync_low_clocks", 32'(winSV), 32'd48);
        check("S.frame_rgb_on_clocks", 32'(winSB), 32'd96);
        check("S.frame_starts_per_frame", 32'(winSF), 32'd1);
        check("S.line_starts_per_frame", 32'(winSL), 32'd10);
        check("scoreboard_drained", 32'(sbQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout cycle=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
